tlc_multi: RTL and testbench

Parametrised two-road traffic light controller: main road rests on green, side road is served on a latched car request, and an emergency input forces a controlled all-red. Phase durations are compile-time parameters and timed by one down-counter. It succeeds the single-road `traffic_light_controller` and drives the lamp outputs of the lab 3 intersection.

---
 rtl/tlc_pkg.sv | 21 ++
 rtl/tlc_timer.sv | 19 +
 rtl/tlc_multi.sv | 89 ++++++++
 tb/tb_tlc_multi.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state encoding and lamp decode for the two-road traffic light controller.
package tlc_pkg;
  typedef enum logic [2:0] {
    MAIN_G, MAIN_Y, RED_TO_SIDE, SIDE_G, SIDE_Y, RED_TO_MAIN, EMERG
  } tlc_state_t;
  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;
  typedef struct packed {
    lamp_t main_l;
    lamp_t side_l;
  } lamp_pair_t;
  function automatic lamp_pair_t state_lamps(input tlc_state_t s);
    lamp_pair_t l;
    l.main_l = s == MAIN_G ? lamp_t'(3'b001) : s == MAIN_Y ? lamp_t'(3'b010) : lamp_t'(3'b100);
    l.side_l = s == SIDE_G ? lamp_t'(3'b001) : s == SIDE_Y ? lamp_t'(3'b010) : lamp_t'(3'b100);
    return l;
  endfunction
endpackage

// File: rtl/tlc_timer.sv
// tlc_timer: saturating down-counter; loads on phase entry and flags done at zero.
module tlc_timer #(
  parameter int CNT_W = 3,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q == '0 ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= RST_VAL;
    else cnt_q <= cnt_d;
  end
  assign done = cnt_q == '0;
endmodule

// File: rtl/tlc_multi.sv
// tlc_multi: two-road traffic light controller; emergency all-red compiled in with TLC_EMERGENCY_EN.
module tlc_multi
  import tlc_pkg::*;
#(
  parameter int GREEN_MIN  = 8,
  parameter int SIDE_GREEN = 6,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic car,
  input  logic emergency,
  output logic main_red,
  output logic main_yellow,
  output logic main_green,
  output logic side_red,
  output logic side_yellow,
  output logic side_green,
  output logic emerg_active
);
  localparam int M1 = GREEN_MIN > SIDE_GREEN ? GREEN_MIN : SIDE_GREEN;
  localparam int M2 = YELLOW > ALL_RED ? YELLOW : ALL_RED;
  localparam int MAX_D = M1 > M2 ? M1 : M2;
  localparam int CNT_W = MAX_D > 1 ? $clog2(MAX_D) : 1;
  tlc_state_t state_q, state_d;
  logic car_req_q, car_req_d, done, load, emerg;
  logic [CNT_W-1:0] load_val;
  int dur_d;
  lamp_pair_t lamps;
`ifdef TLC_EMERGENCY_EN
  assign emerg = emergency;
`else
  logic unused_emergency;
  assign unused_emergency = emergency;
  assign emerg = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MAIN_G:      state_d = emerg || (done && car_req_q) ? MAIN_Y : MAIN_G;
      MAIN_Y:      state_d = done ? (emerg ? EMERG : RED_TO_SIDE) : MAIN_Y;
      RED_TO_SIDE: state_d = emerg ? EMERG : done ? SIDE_G : RED_TO_SIDE;
      SIDE_G:      state_d = emerg || done ? SIDE_Y : SIDE_G;
      SIDE_Y:      state_d = done ? (emerg ? EMERG : RED_TO_MAIN) : SIDE_Y;
      RED_TO_MAIN: state_d = emerg ? EMERG : done ? MAIN_G : RED_TO_MAIN;
`ifdef TLC_EMERGENCY_EN
      EMERG:       state_d = emerg ? EMERG : RED_TO_MAIN;
`endif
      default:     state_d = MAIN_G;
    endcase
  end
  // Every state change reloads the timer with the new phase's duration minus one.
  always_comb begin
    load = state_d != state_q;
    dur_d = state_d == MAIN_G ? GREEN_MIN :
            state_d == SIDE_G ? SIDE_GREEN :
            (state_d == MAIN_Y || state_d == SIDE_Y) ? YELLOW : ALL_RED;
    load_val = CNT_W'(dur_d - 1);
    car_req_d = (load && state_d == SIDE_G) ? 1'b0 : car_req_q | car;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= MAIN_G;
      car_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      car_req_q <= car_req_d;
    end
  end
  tlc_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(CNT_W'(GREEN_MIN - 1))
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .done    (done)
  );
  assign lamps = state_lamps(state_q);
  assign {main_red, main_yellow, main_green} = lamps.main_l;
  assign {side_red, side_yellow, side_green} = lamps.side_l;
`ifdef TLC_EMERGENCY_EN
  assign emerg_active = state_q == EMERG;
`else
  assign emerg_active = 1'b0;
`endif
endmodule

// File: tb/tb_tlc_multi.sv
// tb_tlc_multi: directed scenarios plus randomized run against a phase/age reference model.
module tb_tlc_multi;
  logic clock = 1'b0, reset = 1'b1, car = 1'b0, emergency = 1'b0;
  logic main_red, main_yellow, main_green, side_red, side_yellow, side_green, emerg_active;
  logic [6:0] obs;
  int total = 0, bad = 0;
  localparam logic [6:0] C_MG = 7'b0011000, C_MY = 7'b0101000, C_RR = 7'b1001000;
  localparam logic [6:0] C_SG = 7'b1000010, C_SY = 7'b1000100, C_EM = 7'b1001001;
`ifdef TLC_EMERGENCY_EN
  localparam bit EM_EN = 1'b1;
`else
  localparam bit EM_EN = 1'b0;
`endif
  // Phases: 0 main green, 1 main yellow, 2 red to side, 3 side green, 4 side yellow, 5 red to main, 6 emergency.
  int m_ph = 0, m_age = 0;
  bit m_req = 1'b0;

  tlc_multi dut (
    .clock(clock), .reset(reset), .car(car), .emergency(emergency),
    .main_red(main_red), .main_yellow(main_yellow), .main_green(main_green),
    .side_red(side_red), .side_yellow(side_yellow), .side_green(side_green),
    .emerg_active(emerg_active)
  );
  assign obs = {main_red, main_yellow, main_green, side_red, side_yellow, side_green, emerg_active};
  always #5 clock = ~clock;

  function automatic int dur(input int p);
    return p == 0 ? 8 : p == 3 ? 6 : (p == 1 || p == 4) ? 3 : 2;
  endfunction

  function automatic logic [6:0] m_code();
    case (m_ph)
      0: return C_MG;
      1: return C_MY;
      3: return C_SG;
      4: return C_SY;
      6: return C_EM;
      default: return C_RR;
    endcase
  endfunction

  function automatic logic [6:0] seg_code(input int i);
    int k;
    k = i % 24;
    return k < 8 ? C_MG : k < 11 ? C_MY : k < 13 ? C_RR : k < 19 ? C_SG : k < 22 ? C_SY : C_RR;
  endfunction

  task automatic model_edge(input bit c, input bit e, input bit r);
    int nx;
    bit em, dn;
    em = e && EM_EN;
    dn = m_age >= dur(m_ph) - 1;
    if (r) begin
      m_ph = 0; m_age = 0; m_req = 1'b0;
      return;
    end
    nx = m_ph;
    case (m_ph)
      0: if (em || (dn && m_req)) nx = 1;
      1: if (dn) nx = em ? 6 : 2;
      2: nx = em ? 6 : dn ? 3 : 2;
      3: if (em || dn) nx = 4;
      4: if (dn) nx = em ? 6 : 5;
      5: nx = em ? 6 : dn ? 0 : 5;
      default: if (!em) nx = 5;
    endcase
    m_req = (nx == 3 && m_ph != 3) ? 1'b0 : (m_req | c);
    m_age = nx == m_ph ? m_age + 1 : 0;
    m_ph = nx;
  endtask

  task automatic step(input bit c, input bit e, input bit r);
    car = c; emergency = e; reset = r;
    @(posedge clock);
    model_edge(c, e, r);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 1); step(0, 0, 1);
    total++;
    if (obs !== C_MG) begin bad++; $display("FAIL reset_state got=%b want=%b", obs, C_MG); end
    for (int i = 0; i < 50; i++) begin
      step(0, 0, 0);
      total++;
      if (obs !== C_MG) begin bad++; $display("FAIL idle_main_green cyc=%0d got=%b want=%b", i, obs, C_MG); end
    end
  endtask

  task automatic test_car_pulse();
    step(0, 0, 1); step(0, 0, 1);
    for (int i = 0; i < 30; i++) begin
      if (i > 0) step(i == 2, 0, 0);
      total++;
      if (obs !== seg_code(i)) begin bad++; $display("FAIL car_pulse cyc=%0d got=%b want=%b", i, obs, seg_code(i)); end
    end
  endtask

  task automatic test_car_held();
    step(0, 0, 1); step(0, 0, 1);
    for (int i = 0; i < 72; i++) begin
      if (i > 0) step(1, 0, 0);
      total++;
      if (obs !== seg_code(i)) begin bad++; $display("FAIL car_held cyc=%0d got=%b want=%b", i, obs, seg_code(i)); end
    end
  endtask

`ifdef TLC_EMERGENCY_EN
  task automatic test_emergency();
    logic [6:0] exp;
    int n;
    step(0, 0, 1); step(0, 0, 1); step(1, 0, 0);
    for (n = 0; n < 40 && obs !== C_SG; n++) step(0, 0, 0);
    total++;
    if (obs !== C_SG) begin bad++; $display("FAIL emerg_wait_side_green got=%b want=%b", obs, C_SG); end
    step(0, 0, 0);
    for (int j = 1; j <= 14; j++) begin
      step(j <= 10, j <= 10, 0);
      exp = j <= 3 ? C_SY : j <= 10 ? C_EM : j <= 12 ? C_RR : C_MG;
      total++;
      if (obs !== exp) begin bad++; $display("FAIL emergency step=%0d got=%b want=%b", j, obs, exp); end
    end
  endtask
`else
  task automatic test_no_emerg();
    step(0, 0, 1); step(0, 0, 1);
    for (int i = 0; i < 30; i++) begin
      step(0, ((i / 4) % 2) == 0, 0);
      total++;
      if (obs !== C_MG) begin bad++; $display("FAIL no_emerg cyc=%0d got=%b want=%b", i, obs, C_MG); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    step(0, 0, 1); step(0, 0, 1); step(1, 0, 0);
    for (n = 0; n < 60 && obs !== C_SY; n++) step(0, 0, 0);
    total++;
    if (obs !== C_SY) begin bad++; $display("FAIL reset_mid_wait_side_yellow got=%b want=%b", obs, C_SY); end
    step(0, 0, 0);
    step(0, 0, 1);
    total++;
    if (obs !== C_MG) begin bad++; $display("FAIL reset_mid got=%b want=%b", obs, C_MG); end
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0);
      total++;
      if (obs !== C_MG) begin bad++; $display("FAIL reset_mid_no_service cyc=%0d got=%b want=%b", i, obs, C_MG); end
    end
  endtask

  task automatic test_random();
    bit e;
    e = 1'b0;
    step(0, 0, 1); step(0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) e = ~e;
      step($urandom_range(0, 9) == 0, e, $urandom_range(0, 299) == 0);
      total++;
      if (obs !== m_code()) begin bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, obs, m_code()); end
    end
  endtask

  initial begin
    test_reset();
    test_car_pulse();
    test_car_held();
`ifdef TLC_EMERGENCY_EN
    test_emergency();
`else
    test_no_emerg();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
